// File: rtl/hyperbus_responder_if.sv
// HyperBus device-side pin bundle: controller drives CK/CSN/DQ-in/RWDS-in,
// the responder drives DQ-out/RWDS-out, their enables and busy.
interface hyperbus_responder_if;
  logic       hbus_clk;
  logic       hbus_csn;
  logic [7:0] hbus_dq_i;
  logic [7:0] hbus_dq_o;
  logic       hbus_dq_oe;
  logic       hbus_rwds_i;
  logic       hbus_rwds_o;
  logic       hbus_rwds_oe;
  logic       busy;

  modport master (
    output hbus_clk, hbus_csn, hbus_dq_i, hbus_rwds_i,
    input  hbus_dq_o, hbus_dq_oe, hbus_rwds_o, hbus_rwds_oe, busy
  );

  modport slave (
    input  hbus_clk, hbus_csn, hbus_dq_i, hbus_rwds_i,
    output hbus_dq_o, hbus_dq_oe, hbus_rwds_o, hbus_rwds_oe, busy
  );
endinterface

// File: rtl/hyperbus_responder.sv
// HyperBus memory responder, oversampling CK on clk. Define HBUS_RESPONDER_REG_EN
// to add the ID0/CR0 register space; otherwise register reads return zero.
module hyperbus_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 6
) (
  input  logic clk,
  input  logic rstn,
  hyperbus_responder_if.slave hbus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] LAT_EDGES = 16'(4 * LATENCY);

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, REGW} state_e;

  state_e      state_q, state_d;
  logic        ck_q, csn_q;
  logic [47:0] ca_q, ca_d;
  logic [2:0]  ca_cnt_q, ca_cnt_d;
  logic [15:0] lat_q, lat_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d, reg_q, reg_d;
  logic        byte_q, byte_d;
  logic [7:0]  wbuf_q, wbuf_d;
  logic        wen_hi_q, wen_hi_d;
  logic [7:0]  dq_o_q, dq_o_d;
  logic        rwds_q, rwds_d;
  logic        ck_edge, mem_we, reg_we;
  logic [15:0] rd_word, reg_rd;
  logic [AW-1:0] maddr;
  logic [15:0] mem [DEPTH];

  assign ck_edge = ck_q != hbus.hbus_clk;
  assign maddr   = addr_q[AW-1:0];
  assign rd_word = reg_q ? reg_rd : mem[maddr];

  always_comb begin
    state_d  = state_q;
    ca_d     = ca_q;
    ca_cnt_d = ca_cnt_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    reg_d    = reg_q;
    byte_d   = byte_q;
    wbuf_d   = wbuf_q;
    wen_hi_d = wen_hi_q;
    dq_o_d   = dq_o_q;
    rwds_d   = rwds_q;
    mem_we   = 1'b0;
    reg_we   = 1'b0;
    // CSN high wins over a coincident CK edge; a half-received word is dropped.
    if (hbus.hbus_csn) begin
      state_d = IDLE;
      byte_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (csn_q) begin
          state_d  = CA;
          ca_cnt_d = '0;
        end
        CA: if (ck_edge) begin
          ca_d     = {ca_q[39:0], hbus.hbus_dq_i};
          ca_cnt_d = ca_cnt_q + 3'd1;
          if (ca_cnt_q == 3'd5) begin
            addr_d   = {ca_d[44:16], ca_d[2:0]};
            rd_d     = ca_d[47];
            reg_d    = ca_d[46];
            byte_d   = 1'b0;
            rwds_d   = 1'b0;
            lat_d    = LAT_EDGES;
            ca_cnt_d = '0;
            if (ca_d[46] && !ca_d[47])  state_d = REGW;
            else if (LAT_EDGES == '0)   state_d = ca_d[47] ? RDATA : WDATA;
            else                        state_d = LAT;
          end
        end
        LAT: if (ck_edge) begin
          lat_d = lat_q - 16'd1;
          if (lat_q == 16'd1) state_d = rd_q ? RDATA : WDATA;
        end
        WDATA: if (ck_edge) begin
          if (!byte_q) begin
            wbuf_d   = hbus.hbus_dq_i;
            wen_hi_d = !hbus.hbus_rwds_i;
            byte_d   = 1'b1;
          end else begin
            mem_we = 1'b1;
            byte_d = 1'b0;
            addr_d = addr_q + 32'd1;
          end
        end
        RDATA: if (ck_edge) begin
          if (!byte_q) begin
            dq_o_d = rd_word[15:8];
            rwds_d = 1'b1;
            byte_d = 1'b1;
          end else begin
            dq_o_d = rd_word[7:0];
            rwds_d = 1'b0;
            byte_d = 1'b0;
            addr_d = addr_q + 32'd1;
          end
        end
        // Two bytes only; ca_cnt parks at 2 so later edges are ignored.
        REGW: if (ck_edge && ca_cnt_q != 3'd2) begin
          ca_cnt_d = ca_cnt_q + 3'd1;
          if (ca_cnt_q == 3'd0) wbuf_d = hbus.hbus_dq_i;
          else                  reg_we = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ck_q     <= 1'b0;
      csn_q    <= 1'b0;   // low so a CSN already asserted at release is not taken as a fall
      ca_q     <= '0;
      ca_cnt_q <= '0;
      lat_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      reg_q    <= 1'b0;
      byte_q   <= 1'b0;
      wbuf_q   <= '0;
      wen_hi_q <= 1'b0;
      dq_o_q   <= '0;
      rwds_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ck_q     <= hbus.hbus_clk;
      csn_q    <= hbus.hbus_csn;
      ca_q     <= ca_d;
      ca_cnt_q <= ca_cnt_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      reg_q    <= reg_d;
      byte_q   <= byte_d;
      wbuf_q   <= wbuf_d;
      wen_hi_q <= wen_hi_d;
      dq_o_q   <= dq_o_d;
      rwds_q   <= rwds_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (wen_hi_q)          mem[maddr][15:8] <= wbuf_q;
      if (!hbus.hbus_rwds_i) mem[maddr][7:0]  <= hbus.hbus_dq_i;
    end
  end

`ifdef HBUS_RESPONDER_REG_EN
  logic [15:0] cr0_q, cr0_d;

  always_comb begin
    cr0_d = cr0_q;
    if (reg_we && addr_q == 32'h800) cr0_d = {wbuf_q, hbus.hbus_dq_i};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cr0_q <= 16'h8F1F;
    else       cr0_q <= cr0_d;
  end

  assign reg_rd = (addr_q == 32'h0)   ? 16'h0C81 :
                  (addr_q == 32'h800) ? cr0_q    : 16'h0000;
`else
  logic unused_cfg;
  assign reg_rd     = 16'h0000;
  assign unused_cfg = ^{addr_q[31:AW], reg_we};
`endif

  logic unused_ok;
  assign unused_ok = ^{ca_q[47:40], ca_d[45], ca_d[15:3]};

  assign hbus.hbus_dq_o    = dq_o_q;
  assign hbus.hbus_dq_oe   = state_q == RDATA;
  assign hbus.hbus_rwds_oe = (state_q == CA) || (state_q == RDATA);
  assign hbus.hbus_rwds_o  = (state_q == CA) || ((state_q == RDATA) && rwds_q);
  assign hbus.busy         = state_q != IDLE;
endmodule
